// File: rtl/rv32i_load_store_unit.sv
// rv32i_load_store_unit: single-outstanding RV32I load/store bus master with
// alignment/legality checking, lane steering, load extension and bus timeout.
module rv32i_load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:2] addr_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d, load_data_q, ext_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        one_req, legal, aligned, accept;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        one_req = req_load ^ req_store;
        legal   = req_load ? (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (req_funct3 inside {3'b000, 3'b001, 3'b010});
        aligned = (req_funct3[1:0] == 2'b00) ||
                  (req_funct3[1:0] == 2'b01 && !req_addr[0]) ||
                  (req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
        accept  = state_q == IDLE && one_req && legal && aligned;
        be_d    = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                  req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        lane_b  = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // funct3[2] selects zero extension (LBU/LHU)
        ext_d   = f3_q[1:0] == 2'b00 ? {{24{lane_b[7] & ~f3_q[2]}}, lane_b} :
                  f3_q[1:0] == 2'b01 ? {{16{lane_h[15] & ~f3_q[2]}}, lane_h} : mem_rdata;
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    cnt_d   = 8'd0;
                end else if (req_load || req_store) begin
                    fault_d      = 1'b1;
                    fault_code_d = (one_req && legal) ? 2'b01 : 2'b11;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            load_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            if (accept) begin
                addr_q  <= req_addr[31:2];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                we_q    <= req_store;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
            end
            if (state_q == REQ && mem_ready && !we_q) load_data_q <= ext_d;
        end
    end

    assign stall      = accept || state_q == REQ;
    assign mem_valid  = state_q == REQ;
    assign mem_we     = state_q == REQ && we_q;
    assign mem_addr   = {addr_q, 2'b00};
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign load_valid = state_q == DONE && !we_q;
    assign load_data  = load_data_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// tb_rv32i_load_store_unit: directed vectors with hand-computed expectations
// for the RV32I load/store unit.
module tb_rv32i_load_store_unit;
    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, fault, mem_we, mem_valid, mem_ready;
    logic [1:0]  fault_code;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    int          checks = 0;
    int          errors = 0;

    rv32i_load_store_unit dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .fault(fault), .fault_code(fault_code),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] xbe, input logic [31:0] xd);
        req_load = 1'b1; req_funct3 = f3; req_addr = a;
        #1 check({tag, " stall_idle"}, 32'(stall), 32'd1);
        step();
        req_load = 1'b0;
        check({tag, " valid"}, 32'(mem_valid), 32'd1);
        check({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
        check({tag, " be"}, 32'(mem_be), 32'(xbe));
        check({tag, " we"}, 32'(mem_we), 32'd0);
        mem_ready = 1'b1; mem_rdata = rd;
        step();
        mem_ready = 1'b0;
        check({tag, " load_valid"}, 32'(load_valid), 32'd1);
        check({tag, " data"}, load_data, xd);
        check({tag, " stall_done"}, 32'(stall), 32'd0);
        check({tag, " valid_done"}, 32'(mem_valid), 32'd0);
        step();
        check({tag, " lv_drop"}, 32'(load_valid), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] xbe, input logic [31:0] xwd);
        req_store = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_store = 1'b0;
        check({tag, " be"}, 32'(mem_be), 32'(xbe));
        check({tag, " wdata"}, mem_wdata, xwd);
        check({tag, " we"}, 32'(mem_we), 32'd1);
        check({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check({tag, " no_lv"}, 32'(load_valid), 32'd0);
        check({tag, " stall_done"}, 32'(stall), 32'd0);
        step();
    endtask

    task automatic do_fault(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a, input logic [1:0] code);
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = a;
        #1 check({tag, " stall"}, 32'(stall), 32'd0);
        step();
        req_load = 1'b0; req_store = 1'b0;
        check({tag, " no_valid"}, 32'(mem_valid), 32'd0);
        check({tag, " fault"}, 32'(fault), 32'd1);
        check({tag, " code"}, 32'(fault_code), 32'(code));
        step();
        check({tag, " fault_drop"}, 32'(fault), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        sys_reset = 1'b0; req_load = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst stall", 32'(stall), 32'd0);
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst load_valid", 32'(load_valid), 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst load_data", load_data, 32'd0);
        sys_reset = 1'b1;
        step();

        do_load("LB", 3'b000, 32'h103, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        do_store("SH", 3'b001, 32'h202, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        check("hold load_data", load_data, 32'hFFFF_FF80);
        do_store("SB", 3'b000, 32'h301, 32'h1234_5678, 4'b0010, 32'h7878_7878);
        do_load("LH", 3'b001, 32'h302, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        do_load("LBU", 3'b100, 32'h101, 32'h0000_9A00, 4'b0010, 32'h0000_009A);
        do_load("LHU", 3'b101, 32'h100, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);

        do_fault("LW mis", 1'b1, 1'b0, 3'b010, 32'h005, 2'b01);
        do_fault("LH mis", 1'b1, 1'b0, 3'b001, 32'h011, 2'b01);
        do_fault("both", 1'b1, 1'b1, 3'b010, 32'h000, 2'b11);
        do_fault("f3 011", 1'b1, 1'b0, 3'b011, 32'h000, 2'b11);
        do_fault("SBU", 1'b0, 1'b1, 3'b100, 32'h000, 2'b11);

        // ready while idle must not start anything
        mem_ready = 1'b1;
        step();
        check("idle ready valid", 32'(mem_valid), 32'd0);
        check("idle ready lv", 32'(load_valid), 32'd0);
        mem_ready = 1'b0;

        // timeout: LHU with ready held low
        req_load = 1'b1; req_funct3 = 3'b101; req_addr = 32'h010;
        step();
        req_load = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!mem_valid) break;
            n++;
            step();
        end
        check("to cycles", 32'(n), 32'd255);
        check("to fault", 32'(fault), 32'd1);
        check("to code", 32'(fault_code), 32'd2);
        check("to no_lv", 32'(load_valid), 32'd0);
        check("to stall", 32'(stall), 32'd0);
        step();

        // ready on the final allowed REQ cycle wins over timeout
        req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h020;
        step();
        req_load = 1'b0;
        for (int i = 0; i < 254; i++) step();
        check("edge valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ready = 1'b0;
        check("edge lv", 32'(load_valid), 32'd1);
        check("edge data", load_data, 32'h1234_5678);
        check("edge no_fault", 32'(fault), 32'd0);
        step();

        // reset on third REQ cycle
        req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h040;
        step();
        req_load = 1'b0;
        step();
        step();
        check("rreq valid", 32'(mem_valid), 32'd1);
        sys_reset = 1'b0;
        #1;
        check("rreq valid_drop", 32'(mem_valid), 32'd0);
        check("rreq stall_drop", 32'(stall), 32'd0);
        @(posedge sys_clk);
        #2 sys_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | fault | load_valid | mem_valid;
        end
        check("rreq quiet", 32'(seen), 32'd0);
        do_load("LW post", 3'b010, 32'h044, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
